gc_evaluator_engine: RTL

GC_EVALUATOR_ENGINE -- requirements
Module: gc_evaluator_engine

---
 rtl/gc_evaluator_engine.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/gc_evaluator_engine.sv
// Garbled-circuit evaluator: free-XOR and half-gates AND evaluation, one gate
// per cycle, two fixed-key AES lanes, fixed latency LAT from capture to output.
module gc_evaluator_engine #(
   parameter  int S      = 20,
   parameter  int K      = 128,
   localparam int NR_AES = 10,
   localparam int LAT    = NR_AES + 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [128*(NR_AES+1)-1:0] AES_expandedKey,
   input  logic                      in_valid,
   input  logic [S-1:0]              cid,
   input  logic [S-1:0]              gid,
   input  logic [3:0]                g_logic,
   input  logic [K-1:0]              in0_label,
   input  logic [K-1:0]              in1_label,
   input  logic [K-1:0]              t0,
   input  logic [K-1:0]              t1,
   output logic                      out_valid,
   output logic [K-1:0]              out_label,
   output logic [S-1:0]              out_gid
);

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[8*(255-int'(x)) +: 8];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] dbl(input logic [127:0] x);
      return {x[126:0], 1'b0} ^ (x[127] ? 128'h87 : 128'h0);
   endfunction

   // One AES round; byte 0 of the state is bits [127:120], column-major.
   function automatic logic [127:0] aes_round(input logic [127:0] s,
                                              input logic [127:0] k,
                                              input logic         last);
      logic [7:0]   sb [16];
      logic [7:0]   sr [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] r;
      for (int unsigned i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned w = 0; w < 4; w++)
            sr[w+4*c] = sb[w + 4*((c+w)%4)];
      r = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         a0 = sr[4*c];
         a1 = sr[4*c+1];
         a2 = sr[4*c+2];
         a3 = sr[4*c+3];
         if (last)
            r[127-32*c -: 32] = {a0, a1, a2, a3};
         else
            r[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
      end
      return r ^ k;
   endfunction

   logic [127:0] rk [0:NR_AES];

   always_comb begin
      for (int unsigned r = 0; r <= NR_AES; r++) rk[r] = AES_expandedKey[128*r +: 128];
   end

   logic [K-1:0] tw0, tw1, dx_a, dx_b;
   logic         in_xor;

   always_comb begin
      tw0 = '0;
      tw1 = '0;
      tw0[2*S:0] = {cid, gid, 1'b0};
      tw1[2*S:0] = {cid, gid, 1'b1};
      dx_a   = dbl(in0_label) ^ tw0;
      dx_b   = dbl(in1_label) ^ tw1;
      in_xor = (g_logic == 4'b0110) || (g_logic == 4'b1001);
   end

   logic [127:0] pw_a  [1:LAT];
   logic [127:0] pw_b  [1:LAT];
   logic [127:0] wa_q  [1:LAT];
   logic [127:0] t0_q  [1:LAT];
   logic [127:0] t1_q  [1:LAT];
   logic [S-1:0] gid_q [1:LAT];
   logic [127:0] st_a  [2:LAT];
   logic [127:0] st_b  [2:LAT];
   logic [LAT:1] sa_q, sb_q, xr_q, vld;

   // Key whitening has its own stage so the result lands LAT edges after capture.
   // XOR gates never read t0, so their Wb rides in the t0 slot.
   always_ff @(posedge clk) begin
      pw_a[1]  <= dx_a;
      pw_b[1]  <= dx_b;
      wa_q[1]  <= in0_label;
      t0_q[1]  <= in_xor ? in1_label : t0;
      t1_q[1]  <= t1;
      gid_q[1] <= gid;
      sa_q     <= {sa_q[LAT-1:1], in0_label[0]};
      sb_q     <= {sb_q[LAT-1:1], in1_label[0]};
      xr_q     <= {xr_q[LAT-1:1], in_xor};
      for (int unsigned i = 2; i <= LAT; i++) begin
         pw_a[i]  <= pw_a[i-1];
         pw_b[i]  <= pw_b[i-1];
         wa_q[i]  <= wa_q[i-1];
         t0_q[i]  <= t0_q[i-1];
         t1_q[i]  <= t1_q[i-1];
         gid_q[i] <= gid_q[i-1];
      end
      st_a[2] <= pw_a[1] ^ rk[0];
      st_b[2] <= pw_b[1] ^ rk[0];
      for (int unsigned r = 1; r <= NR_AES; r++) begin
         st_a[r+2] <= aes_round(st_a[r+1], rk[r], r == NR_AES);
         st_b[r+2] <= aes_round(st_b[r+1], rk[r], r == NR_AES);
      end
   end

   logic [127:0] and_lbl, nxt_lbl;

   always_comb begin
      and_lbl = st_a[LAT] ^ pw_a[LAT] ^ st_b[LAT] ^ pw_b[LAT];
      if (sa_q[LAT]) and_lbl = and_lbl ^ t0_q[LAT];
      if (sb_q[LAT]) and_lbl = and_lbl ^ t1_q[LAT] ^ wa_q[LAT];
      nxt_lbl = xr_q[LAT] ? (wa_q[LAT] ^ t0_q[LAT]) : and_lbl;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld       <= '0;
         out_valid <= 1'b0;
         out_label <= '0;
         out_gid   <= '0;
      end else begin
         vld       <= {vld[LAT-1:1], in_valid};
         out_valid <= vld[LAT];
         if (vld[LAT]) begin
            out_label <= nxt_lbl;
            out_gid   <= gid_q[LAT];
         end
      end
   end

endmodule
